// File: rtl/zemina90_bank_ctrl_pkg.sv
// Shared definitions for the Zemina 90-in-1 bank-select front end and the
// mapper that consumes its segment number.
package zemina90_bank_ctrl_pkg;

    // Register mode field bank_reg[7:6]; both 0x encodings select 16K mode.
    typedef enum logic [1:0] {
        MODE_16K_A    = 2'b00,
        MODE_16K_B    = 2'b01,
        MODE_32K      = 2'b10,
        MODE_32K_SWAP = 2'b11
    } zem90_mode_t;

    localparam logic [7:0] ZEM90_IO_PORT   = 8'h77;
    localparam logic [7:0] ZEM90_RESET_VAL = 8'h00;
    localparam logic [7:0] SEG_NONE        = 8'hFF;

    // The mapped window is pages 1 and 2 (0x4000-0xBFFF).
    function automatic logic in_window(input logic [1:0] page);
        return (page == 2'b01) || (page == 2'b10);
    endfunction

endpackage

// File: rtl/zemina90_bank_ctrl_io_write_edge.sv
// Qualifies a CPU I/O write to one port and turns it into a single capture
// pulse per strobe assertion, plus a registered acknowledge the cycle after.
// Written to be reusable by other I/O-banked mappers.
module zemina90_bank_ctrl_io_write_edge #(
    parameter logic [7:0] IO_PORT = 8'h77
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       soft_reset_i,
    input  logic       enable_i,
    input  logic       iorq_i,
    input  logic       wr_i,
    input  logic [7:0] io_addr_i,
    output logic       capture_o,
    output logic       write_ack_o
);

    logic strb_s;
    logic strb_q;
    logic ack_q;

    // A strobe is only meaningful when the slot carries this mapper type.
    assign strb_s = enable_i & iorq_i & wr_i & (io_addr_i == IO_PORT);

    // Rising edge only; soft reset suppresses the capture so no ack follows.
    assign capture_o   = strb_s & ~strb_q & ~soft_reset_i;
    assign write_ack_o = ack_q;

    // Remember the previous strobe level and register the capture as the ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strb_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            strb_q <= strb_s;
            ack_q  <= capture_o;
        end
    end

endmodule

// File: rtl/zemina90_bank_ctrl.sv
// Bank-select front end for the Zemina 90-in-1 cartridge: holds the
// bank/mode register written through an I/O port and decodes the 8 KB
// segment number for the live CPU memory address.
module zemina90_bank_ctrl
    import zemina90_bank_ctrl_pkg::*;
#(
    parameter logic [7:0] IO_PORT   = ZEM90_IO_PORT,
    parameter logic [7:0] RESET_VAL = ZEM90_RESET_VAL
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        soft_reset,
    input  logic        iorq,
    input  logic        wr,
    input  logic [7:0]  io_addr,
    input  logic [7:0]  data_in,
    input  logic [15:0] addr,
    output logic [7:0]  seg_out,
    output logic        seg_hit,
    output logic [7:0]  bank_reg,
    output logic        write_ack
);

    logic        capture_s;
    logic [7:0]  bank_d;
    logic [7:0]  bank_q;
    zem90_mode_t mode_s;
    logic [5:0]  bank_b_s;
    logic [5:0]  bank16_s;
    logic        addr_unused_s;

    zemina90_bank_ctrl_io_write_edge #(
        .IO_PORT (IO_PORT)
    ) u_io_write_edge (
        .clk          (clk),
        .reset_n      (reset_n),
        .soft_reset_i (soft_reset),
        .enable_i     (enable),
        .iorq_i       (iorq),
        .wr_i         (wr),
        .io_addr_i    (io_addr),
        .capture_o    (capture_s),
        .write_ack_o  (write_ack)
    );

    // Next register value: soft reset has priority over a capture.
    always_comb begin
        bank_d = bank_q;
        if (soft_reset) begin
            bank_d = RESET_VAL;
        end else if (capture_s) begin
            bank_d = data_in;
        end else begin
            bank_d = bank_q;
        end
    end

    // Bank/mode register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_q <= RESET_VAL;
        end else begin
            bank_q <= bank_d;
        end
    end

    assign bank_reg      = bank_q;
    assign mode_s        = zem90_mode_t'(bank_q[7:6]);
    assign bank_b_s      = bank_q[5:0];
    assign addr_unused_s = ^addr[12:0];

    // Segment decode from the registered bank and the live address; the
    // 32K modes pair banks by masking bit 0 so B=3F never wraps.
    always_comb begin
        bank16_s = bank_b_s;
        seg_out  = SEG_NONE;
        seg_hit  = 1'b0;
        if (in_window(addr[15:14])) begin
            seg_hit = 1'b1;
            case (mode_s)
                MODE_32K: begin
                    bank16_s = (addr[15:14] == 2'b01) ? (bank_b_s & 6'h3E)
                                                      : (bank_b_s | 6'h01);
                end
                MODE_32K_SWAP: begin
                    bank16_s = (addr[15:14] == 2'b01) ? (bank_b_s | 6'h01)
                                                      : (bank_b_s & 6'h3E);
                end
                default: begin
                    bank16_s = bank_b_s;
                end
            endcase
            seg_out = {1'b0, bank16_s, addr[13]};
        end else begin
            bank16_s = bank_b_s;
            seg_out  = SEG_NONE;
            seg_hit  = 1'b0;
        end
    end

endmodule

// File: tb/tb_zemina90_bank_ctrl.sv
// Self-checking bench for zemina90_bank_ctrl: directed scenarios plus a
// randomized run, all compared against a behavioural model of the register
// and segment decode.
module tb_zemina90_bank_ctrl;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        soft_reset;
    logic        iorq;
    logic        wr;
    logic [7:0]  io_addr;
    logic [7:0]  data_in;
    logic [15:0] addr;
    logic [7:0]  seg_out;
    logic        seg_hit;
    logic [7:0]  bank_reg;
    logic        write_ack;

    int n_checks;
    int n_errors;

    // Model state: register value, previous strobe level, expected ack.
    int  m_bank;
    bit  m_prev_strb;
    bit  m_ack;

    zemina90_bank_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .soft_reset (soft_reset),
        .iorq       (iorq),
        .wr         (wr),
        .io_addr    (io_addr),
        .data_in    (data_in),
        .addr       (addr),
        .seg_out    (seg_out),
        .seg_hit    (seg_hit),
        .bank_reg   (bank_reg),
        .write_ack  (write_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Segment number from the register rules, using plain arithmetic.
    task automatic model_seg(input int breg, input int a, output int s, output int h);
        int page;
        int b;
        int mode;
        int bank;
        int odd;
        page = a / 16384;
        if (page == 1 || page == 2) begin
            b    = breg % 64;
            mode = breg / 64;
            if (mode < 2) begin
                bank = b;
            end else begin
                odd = (page == 2) ? 1 : 0;
                if (mode == 3) odd = 1 - odd;
                bank = (b / 2) * 2 + odd;
            end
            s = bank * 2 + (a / 8192) % 2;
            h = 1;
        end else begin
            s = 255;
            h = 0;
        end
    endtask

    task automatic check_decode(input string tag);
        int s;
        int h;
        model_seg(m_bank, int'(addr), s, h);
        check_eq({tag, "_seg"}, 32'(seg_out), 32'(s));
        check_eq({tag, "_hit"}, 32'(seg_hit), 32'(h));
    endtask

    // One clock cycle: drive, check decode pre-edge, advance model, check state.
    task automatic cyc(input logic en, input logic sr, input logic io, input logic w,
                       input logic [7:0] ioa, input logic [7:0] d, input logic [15:0] a,
                       input string tag);
        bit strb;
        enable     = en;
        soft_reset = sr;
        iorq       = io;
        wr         = w;
        io_addr    = ioa;
        data_in    = d;
        addr       = a;
        #1;
        check_decode({tag, "_pre"});
        strb = en && io && w && (ioa == 8'h77);
        @(posedge clk);
        if (!reset_n) begin
            m_bank      = 0;
            m_prev_strb = 1'b0;
            m_ack       = 1'b0;
        end else begin
            m_ack = strb && !m_prev_strb && !sr;
            if (sr)         m_bank = 0;
            else if (m_ack) m_bank = int'(d);
            m_prev_strb = strb;
        end
        #1;
        check_eq({tag, "_bank"}, 32'(bank_reg), 32'(m_bank));
        check_eq({tag, "_ack"}, 32'(write_ack), 32'(m_ack));
    endtask

    task automatic port_write(input logic [7:0] d, input string tag);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h77, d, addr, tag);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, addr, {tag, "_idle"});
    endtask

    task automatic expect_seg(input logic [15:0] a, input logic [7:0] s, input logic h,
                              input string tag);
        addr = a;
        #1;
        check_eq({tag, "_seg"}, 32'(seg_out), 32'(s));
        check_eq({tag, "_hit"}, 32'(seg_hit), 32'(h));
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        m_bank      = 0;
        m_prev_strb = 1'b0;
        m_ack       = 1'b0;
        reset_n     = 1'b0;
        enable      = 1'b1;
        soft_reset  = 1'b0;
        iorq        = 1'b0;
        wr          = 1'b0;
        io_addr     = 8'h00;
        data_in     = 8'h00;
        addr        = 16'h4000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_eq("rst_bank", 32'(bank_reg), 32'h00);
        check_eq("rst_ack", 32'(write_ack), 32'h0);
        expect_seg(16'h4000, 8'h00, 1'b1, "rst");

        // 16K mode
        port_write(8'h05, "w05");
        check_eq("w05_reg", 32'(bank_reg), 32'h05);
        expect_seg(16'h6000, 8'h0B, 1'b1, "m16_6000");
        expect_seg(16'hA000, 8'h0B, 1'b1, "m16_a000");
        expect_seg(16'h8000, 8'h0A, 1'b1, "m16_8000");

        // 32K and 32K swap
        port_write(8'h85, "w85");
        expect_seg(16'h4000, 8'h08, 1'b1, "m32_4000");
        expect_seg(16'h8000, 8'h0A, 1'b1, "m32_8000");
        port_write(8'hC4, "wc4");
        expect_seg(16'h4000, 8'h0A, 1'b1, "swp_4000");
        expect_seg(16'h8000, 8'h08, 1'b1, "swp_8000");

        // No carry at the top bank
        port_write(8'hBF, "wbf");
        expect_seg(16'h4000, 8'h7C, 1'b1, "m32_top_4000");
        expect_seg(16'hA000, 8'h7F, 1'b1, "m32_top_a000");

        // Held strobe: first cycle's data, one ack
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 8'h11, 16'h4000, "held0");
        for (int i = 1; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 8'h22, 16'h4000, "heldn");
        end
        check_eq("held_reg", 32'(bank_reg), 32'h11);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h77, 8'h22, 16'h4000, "held_rel");

        // Gating: wrong port, then enable low
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h76, 8'h3C, 16'h4000, "port76");
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 8'h3D, 16'h4000, "en0");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h4000, "gate_idle");
        check_eq("gate_reg", 32'(bank_reg), 32'h11);
        expect_seg(16'h0000, 8'hFF, 1'b0, "out_0000");
        expect_seg(16'hC000, 8'hFF, 1'b0, "out_c000");

        // Same-cycle write and access: decode shows pre-write value
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 8'h07, 16'h6000, "same");
        expect_seg(16'h6000, 8'h0F, 1'b1, "same_after");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h6000, "same_idle");

        // Soft reset wins over a simultaneous capture
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h77, 8'h5A, 16'h4000, "srst");
        check_eq("srst_reg", 32'(bank_reg), 32'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h4000, "srst_idle");

        // Reset asserted mid-strobe, released with strobe held
        port_write(8'h2A, "w2a");
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 8'h33, 16'h4000, "mid0");
        reset_n = 1'b0;
        m_bank      = 0;
        m_prev_strb = 1'b0;
        m_ack       = 1'b0;
        #1;
        check_eq("async_rst_bank", 32'(bank_reg), 32'h00);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 8'h33, 16'h4000, "in_rst");
        reset_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 8'h44, 16'h4000, "rel0");
        check_eq("rel_reg", 32'(bank_reg), 32'h44);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 8'h55, 16'h4000, "rel1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h4000, "rel_idle");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        r_en;
            logic        r_sr;
            logic        r_io;
            logic        r_wr;
            logic [7:0]  r_port;
            r_en   = ($urandom_range(0, 7) != 0);
            r_sr   = ($urandom_range(0, 15) == 0);
            r_io   = ($urandom_range(0, 2) != 0);
            r_wr   = ($urandom_range(0, 2) != 0);
            r_port = ($urandom_range(0, 3) != 0) ? 8'h77 : 8'($urandom_range(0, 255));
            cyc(r_en, r_sr, r_io, r_wr, r_port, 8'($urandom_range(0, 255)),
                16'($urandom_range(0, 65535)), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
